// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one byte-wide UART transmitter among NREQ requesters. Arbitration
// is round robin. The winning requester keeps the transmitter until it sends
// a byte flagged last, so messages are never interleaved. Two timers recover
// from a transmitter that never reports busy and from an owner that stalls
// mid-message.
//
// Ports
//   sys_clk_i     system clock
//   sys_rst_i     synchronous active-high reset
//   req_valid_i   per-requester byte valid
//   req_data_i    per-requester byte, requester i on [8i+7:8i]
//   req_last_i    byte is the final byte of its message
//   req_ready_o   byte accepted when valid and ready are both high
//   grant_o       one-hot current owner, zero when there is no owner
//   uart_wr_o     one-cycle write strobe to the transmitter
//   uart_dat_o    byte to the transmitter, valid while uart_wr_o is high
//   uart_busy_i   transmitter busy
//   err_timeout_o one-cycle pulse on a busy or hold timeout
//   active_o      high whenever the arbiter is not idle
module uart_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int BUSY_TIMEOUT = 15,
    parameter int HOLD_TIMEOUT = 1023
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [8*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]   req_last_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   grant_o,
    output logic              uart_wr_o,
    output logic [7:0]        uart_dat_o,
    input  logic              uart_busy_i,
    output logic              err_timeout_o,
    output logic              active_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW    = $clog2(HOLD_TIMEOUT + 1);
    localparam int BW    = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    state_t            state_r, state_n;
    logic [NREQ-1:0]   grant_r, grant_n;
    logic [IDX_W-1:0]  owner_r, owner_n;
    logic [IDX_W-1:0]  ptr_r, ptr_n;
    logic              last_r, last_n;
    logic              wr_r, wr_n;
    logic [7:0]        dat_r, dat_n;
    logic              err_r, err_n;
    logic              active_r, active_n;
    logic [HW-1:0]     hold_cnt_r, hold_cnt_n;
    logic [BW-1:0]     busy_cnt_r, busy_cnt_n;

    logic [IDX_W-1:0]  pick_s;
    logic              pick_found_s;
    logic [IDX_W-1:0]  cand_s;
    logic              owner_valid_s;
    logic              owner_last_s;
    logic [7:0]        owner_data_s;
    logic [NREQ-1:0]   req_ready_s;

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] one_v;
        one_v = {{(NREQ-1){1'b0}}, 1'b1};
        return one_v << idx;
    endfunction

    assign owner_valid_s = req_valid_i[owner_r];
    assign owner_last_s  = req_last_i[owner_r];
    assign owner_data_s  = req_data_i[{owner_r, 3'b000} +: 8];

    // Round-robin pick: first valid requester at or after ptr+1, wrapping.
    always_comb begin
        pick_s       = '0;
        pick_found_s = 1'b0;
        cand_s       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_s = IDX_W'((int'(ptr_r) + k) % NREQ);
            if (!pick_found_s && req_valid_i[cand_s]) begin
                pick_found_s = 1'b1;
                pick_s       = cand_s;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Ready is offered only to the owner, only in HOLD and only while the
    // transmitter is free; it deliberately ignores the owner's valid.
    always_comb begin
        if ((state_r == ST_HOLD) && !uart_busy_i) begin
            req_ready_s = grant_r;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state_r;
        grant_n    = grant_r;
        owner_n    = owner_r;
        ptr_n      = ptr_r;
        last_n     = last_r;
        wr_n       = 1'b0;
        dat_n      = dat_r;
        err_n      = 1'b0;
        hold_cnt_n = hold_cnt_r;
        busy_cnt_n = busy_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    owner_n    = pick_s;
                    grant_n    = idx_to_onehot(pick_s);
                    state_n    = ST_HOLD;
                    hold_cnt_n = '0;
                    busy_cnt_n = '0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (owner_valid_s && !uart_busy_i) begin
                    wr_n       = 1'b1;
                    dat_n      = owner_data_s;
                    last_n     = owner_last_s;
                    state_n    = ST_WAIT_BUSY;
                    hold_cnt_n = '0;
                    busy_cnt_n = '0;
                end else if (owner_valid_s) begin
                    hold_cnt_n = '0;
                end else if (hold_cnt_r == HW'(HOLD_TIMEOUT - 1)) begin
                    // Owner stalled mid-message: revoke the lock.
                    err_n      = 1'b1;
                    grant_n    = '0;
                    ptr_n      = owner_r;
                    state_n    = ST_IDLE;
                    hold_cnt_n = '0;
                    busy_cnt_n = '0;
                end else begin
                    hold_cnt_n = hold_cnt_r + HW'(1);
                end
            end
            ST_WAIT_BUSY: begin
                if (uart_busy_i) begin
                    state_n    = ST_WAIT_DONE;
                    hold_cnt_n = '0;
                    busy_cnt_n = '0;
                end else if (busy_cnt_r == BW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged the write.
                    err_n      = 1'b1;
                    grant_n    = '0;
                    ptr_n      = owner_r;
                    state_n    = ST_IDLE;
                    hold_cnt_n = '0;
                    busy_cnt_n = '0;
                end else begin
                    busy_cnt_n = busy_cnt_r + BW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy_i && last_r) begin
                    grant_n    = '0;
                    ptr_n      = owner_r;
                    state_n    = ST_IDLE;
                    hold_cnt_n = '0;
                    busy_cnt_n = '0;
                end else if (!uart_busy_i) begin
                    state_n    = ST_HOLD;
                    hold_cnt_n = '0;
                    busy_cnt_n = '0;
                end else begin
                    state_n = ST_WAIT_DONE;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                grant_n    = '0;
                hold_cnt_n = '0;
                busy_cnt_n = '0;
            end
        endcase
        active_n = (state_n != ST_IDLE);
    end

    // State and registered outputs; pointer resets so requester 0 wins first.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            owner_r    <= '0;
            ptr_r      <= IDX_W'(NREQ - 1);
            last_r     <= 1'b0;
            wr_r       <= 1'b0;
            dat_r      <= 8'h00;
            err_r      <= 1'b0;
            active_r   <= 1'b0;
            hold_cnt_r <= '0;
            busy_cnt_r <= '0;
        end else begin
            state_r    <= state_n;
            grant_r    <= grant_n;
            owner_r    <= owner_n;
            ptr_r      <= ptr_n;
            last_r     <= last_n;
            wr_r       <= wr_n;
            dat_r      <= dat_n;
            err_r      <= err_n;
            active_r   <= active_n;
            hold_cnt_r <= hold_cnt_n;
            busy_cnt_r <= busy_cnt_n;
        end
    end

    assign req_ready_o   = req_ready_s;
    assign grant_o       = grant_r;
    assign uart_wr_o     = wr_r;
    assign uart_dat_o    = dat_r;
    assign err_timeout_o = err_r;
    assign active_o      = active_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: per-requester byte queues drive the inputs,
// a transmitter model answers write strobes with a busy window, and a monitor
// pops expected {grant, byte} pairs from a scoreboard on every strobe.
module tb_uart_tx_arbiter;

    localparam int NREQ     = 4;
    localparam int BUSY_TO  = 15;
    localparam int HOLD_TO  = 8;
    localparam int BUSY_LEN = 3;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
    } exp_t;

    logic        sys_clk_i   = 1'b0;
    logic        sys_rst_i   = 1'b1;
    logic [3:0]  req_valid_i = 4'b0000;
    logic [31:0] req_data_i  = 32'h0;
    logic [3:0]  req_last_i  = 4'b0000;
    logic        uart_busy_i = 1'b0;
    logic [3:0]  req_ready_o;
    logic [3:0]  grant_o;
    logic        uart_wr_o;
    logic [7:0]  uart_dat_o;
    logic        err_timeout_o;
    logic        active_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic busy_en  = 1'b1;

    exp_t       exp_q[$];
    logic [8:0] req_q[NREQ][$];

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .BUSY_TIMEOUT (BUSY_TO),
        .HOLD_TIMEOUT (HOLD_TO)
    ) dut (
        .sys_clk_i     (sys_clk_i),
        .sys_rst_i     (sys_rst_i),
        .req_valid_i   (req_valid_i),
        .req_data_i    (req_data_i),
        .req_last_i    (req_last_i),
        .req_ready_o   (req_ready_o),
        .grant_o       (grant_o),
        .uart_wr_o     (uart_wr_o),
        .uart_dat_o    (uart_dat_o),
        .uart_busy_i   (uart_busy_i),
        .err_timeout_o (err_timeout_o),
        .active_o      (active_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    always @(posedge sys_clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, req);
        end
    endtask

    // Requester driver: present the queue head, pop it after a handshake.
    initial begin
        logic [3:0] hs;
        logic [8:0] f;
        forever begin
            @(negedge sys_clk_i);
            hs = req_valid_i & req_ready_o;
            @(posedge sys_clk_i);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
                if (req_q[i].size() > 0) begin
                    f = req_q[i][0];
                    req_valid_i[i]          = 1'b1;
                    req_data_i[i*8 +: 8]    = f[7:0];
                    req_last_i[i]           = f[8];
                end else begin
                    req_valid_i[i] = 1'b0;
                    req_last_i[i]  = 1'b0;
                end
            end
        end
    end

    // Transmitter model: busy rises one cycle after a strobe for BUSY_LEN cycles.
    initial begin
        forever begin
            @(posedge sys_clk_i);
            #1;
            if (uart_wr_o === 1'b1 && busy_en) begin
                @(posedge sys_clk_i);
                #1 uart_busy_i = 1'b1;
                repeat (BUSY_LEN) @(posedge sys_clk_i);
                #1 uart_busy_i = 1'b0;
            end
        end
    end

    // Scoreboard monitor: every strobe must match the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk_i);
            if (uart_wr_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL strobe_unexpected: actual data %0h grant %b, required no strobe",
                             uart_dat_o, grant_o);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_grant", {28'h0, grant_o}, {28'h0, e.grant});
                    check("strobe_data", {24'h0, uart_dat_o}, {24'h0, e.data});
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge sys_clk_i);
        sys_rst_i = 1'b1;
        busy_en   = 1'b1;
        for (int i = 0; i < NREQ; i++) req_q[i].delete();
        repeat (2) @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge sys_clk_i);
            #2;
            if (exp_q.size() == 0 && req_valid_i == 4'b0000 && !active_o && !uart_busy_i) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_strobe(input string name, output int c);
        logic ok;
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge sys_clk_i);
            #2;
            if (uart_wr_o) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
        check(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_grant(input string name, input logic [3:0] req);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge sys_clk_i);
            #2;
            if (grant_o != 4'b0000) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'h0, ok}, 32'h1);
        check({name, "_value"}, {28'h0, grant_o}, {28'h0, req});
    endtask

    initial begin
        int   c0, c1, idle_cnt;
        logic found;

        // Reset values
        repeat (3) @(posedge sys_clk_i);
        #2;
        check("reset_grant", {28'h0, grant_o}, 32'h0);
        check("reset_ready", {28'h0, req_ready_o}, 32'h0);
        check("reset_wr", {31'h0, uart_wr_o}, 32'h0);
        check("reset_dat", {24'h0, uart_dat_o}, 32'h0);
        check("reset_err", {31'h0, err_timeout_o}, 32'h0);
        check("reset_active", {31'h0, active_o}, 32'h0);
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;

        // Single byte: grant at cycle 1, strobe at cycle 2
        @(negedge sys_clk_i);
        req_q[0].push_back({1'b1, 8'h41});
        exp_q.push_back({4'b0001, 8'h41});
        @(posedge sys_clk_i);
        @(posedge sys_clk_i);
        #2;
        check("single_grant_c1", {28'h0, grant_o}, 32'h1);
        check("single_ready_c1", {28'h0, req_ready_o}, 32'h1);
        @(posedge sys_clk_i);
        #2;
        check("single_wr_c2", {31'h0, uart_wr_o}, 32'h1);
        check("single_dat_c2", {24'h0, uart_dat_o}, 32'h41);
        wait_idle("single_idle");
        check("single_grant_end", {28'h0, grant_o}, 32'h0);

        // Locking: req0 three-byte message while req1 waits
        do_reset();
        req_q[0].push_back({1'b0, 8'h10});
        req_q[0].push_back({1'b0, 8'h11});
        req_q[0].push_back({1'b1, 8'h12});
        req_q[1].push_back({1'b1, 8'h55});
        exp_q.push_back({4'b0001, 8'h10});
        exp_q.push_back({4'b0001, 8'h11});
        exp_q.push_back({4'b0001, 8'h12});
        exp_q.push_back({4'b0010, 8'h55});
        wait_idle("lock_idle");

        // Round robin: all four valid, two single-byte messages each
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                req_q[i].push_back({1'b1, 8'hA0 + 8'(16 * r + i)});
                exp_q.push_back({4'b0001 << i, 8'hA0 + 8'(16 * r + i)});
            end
        end
        wait_idle("rr_idle");

        // Busy timeout: transmitter never goes busy for req0
        do_reset();
        busy_en = 1'b0;
        req_q[0].push_back({1'b1, 8'h77});
        req_q[1].push_back({1'b1, 8'h88});
        exp_q.push_back({4'b0001, 8'h77});
        exp_q.push_back({4'b0010, 8'h88});
        wait_strobe("busyto_strobe", c0);
        found = 1'b0;
        c1    = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge sys_clk_i);
            #2;
            if (err_timeout_o) begin
                found = 1'b1;
                c1    = cyc;
                break;
            end
        end
        check("busyto_seen", {31'h0, found}, 32'h1);
        check("busyto_delay", c1 - c0, 32'd15);
        check("busyto_grant", {28'h0, grant_o}, 32'h0);
        busy_en = 1'b1;
        @(posedge sys_clk_i);
        #2;
        check("busyto_pulse_len", {31'h0, err_timeout_o}, 32'h0);
        wait_idle("busyto_idle");

        // Hold timeout: req2 stalls after a non-last byte, req3 then served
        do_reset();
        req_q[2].push_back({1'b0, 8'h21});
        req_q[3].push_back({1'b1, 8'h31});
        exp_q.push_back({4'b0100, 8'h21});
        exp_q.push_back({4'b1000, 8'h31});
        found    = 1'b0;
        idle_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge sys_clk_i);
            #2;
            if (req_ready_o[2] && !req_valid_i[2]) idle_cnt++;
            if (err_timeout_o) begin
                found = 1'b1;
                break;
            end
        end
        check("holdto_seen", {31'h0, found}, 32'h1);
        check("holdto_idle_cycles", idle_cnt, 32'd8);
        check("holdto_grant", {28'h0, grant_o}, 32'h0);
        wait_grant("holdto_next", 4'b1000);
        wait_idle("holdto_idle");

        // Reset mid-message in WAIT_DONE
        do_reset();
        req_q[0].push_back({1'b0, 8'h61});
        req_q[0].push_back({1'b1, 8'h62});
        req_q[1].push_back({1'b1, 8'h71});
        exp_q.push_back({4'b0001, 8'h61});
        wait_strobe("rst_strobe", c0);
        @(posedge sys_clk_i);
        #2;
        check("rst_busy_seen", {31'h0, uart_busy_i}, 32'h1);
        @(posedge sys_clk_i);
        #2;
        check("rst_active_before", {31'h0, active_o}, 32'h1);
        @(negedge sys_clk_i);
        sys_rst_i = 1'b1;
        req_q[0].delete();
        req_q[0].push_back({1'b1, 8'h63});
        exp_q.push_back({4'b0001, 8'h63});
        exp_q.push_back({4'b0010, 8'h71});
        @(posedge sys_clk_i);
        #2;
        check("rst_grant", {28'h0, grant_o}, 32'h0);
        check("rst_wr", {31'h0, uart_wr_o}, 32'h0);
        check("rst_active", {31'h0, active_o}, 32'h0);
        @(negedge sys_clk_i);
        sys_rst_i = 1'b0;
        wait_grant("rst_first_grant", 4'b0001);
        wait_idle("rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
